// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Execute-stage ALU with a valid/ready handshake. It covers the RV32I/RV64I ALU
// and branch operations and the M extension. Base operations and multiplies
// produce a registered result one cycle after accept. DIV/DIVU/REM/REMU run
// through a radix-2 restoring divider that retires one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved in one cycle without
// iterating.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operation on alucode/op1/op2 is valid
//   in_ready   block accepts an operation this cycle
//   alucode    operation select (ALU_* codes below)
//   op1, op2   operands (rs1/PC, rs2/immediate)
//   out_valid  result/br_taken are valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   br_taken   registered branch/jump-taken flag
//   busy       divider is iterating
//
// Operation codes (6 bits)
//   0 ADD   1 SUB   2 SLT   3 SLTU  4 XOR   5 OR    6 AND   7 SLL
//   8 SRL   9 SRA  10 LUI  11 JAL  12 JALR 13 BEQ  14 BNE  15 BLT
//  16 BGE  17 BLTU 18 BGEU 19 LB   20 LH   21 LW   22 LBU  23 LHU
//  24 SB   25 SH   26 SW   27 MUL  28 MULH 29 MULHSU 30 MULHU
//  31 DIV  32 DIVU 33 REM  34 REMU          other codes: result 0
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      alucode,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            busy
);

    localparam logic [5:0] ALU_ADD    = 6'd0;
    localparam logic [5:0] ALU_SUB    = 6'd1;
    localparam logic [5:0] ALU_SLT    = 6'd2;
    localparam logic [5:0] ALU_SLTU   = 6'd3;
    localparam logic [5:0] ALU_XOR    = 6'd4;
    localparam logic [5:0] ALU_OR     = 6'd5;
    localparam logic [5:0] ALU_AND    = 6'd6;
    localparam logic [5:0] ALU_SLL    = 6'd7;
    localparam logic [5:0] ALU_SRL    = 6'd8;
    localparam logic [5:0] ALU_SRA    = 6'd9;
    localparam logic [5:0] ALU_LUI    = 6'd10;
    localparam logic [5:0] ALU_JAL    = 6'd11;
    localparam logic [5:0] ALU_JALR   = 6'd12;
    localparam logic [5:0] ALU_BEQ    = 6'd13;
    localparam logic [5:0] ALU_BNE    = 6'd14;
    localparam logic [5:0] ALU_BLT    = 6'd15;
    localparam logic [5:0] ALU_BGE    = 6'd16;
    localparam logic [5:0] ALU_BLTU   = 6'd17;
    localparam logic [5:0] ALU_BGEU   = 6'd18;
    localparam logic [5:0] ALU_LB     = 6'd19;
    localparam logic [5:0] ALU_LH     = 6'd20;
    localparam logic [5:0] ALU_LW     = 6'd21;
    localparam logic [5:0] ALU_LBU    = 6'd22;
    localparam logic [5:0] ALU_LHU    = 6'd23;
    localparam logic [5:0] ALU_SB     = 6'd24;
    localparam logic [5:0] ALU_SH     = 6'd25;
    localparam logic [5:0] ALU_SW     = 6'd26;
    localparam logic [5:0] ALU_MUL    = 6'd27;
    localparam logic [5:0] ALU_MULH   = 6'd28;
    localparam logic [5:0] ALU_MULHSU = 6'd29;
    localparam logic [5:0] ALU_MULHU  = 6'd30;
    localparam logic [5:0] ALU_DIV    = 6'd31;
    localparam logic [5:0] ALU_DIVU   = 6'd32;
    localparam logic [5:0] ALU_REM    = 6'd33;
    localparam logic [5:0] ALU_REMU   = 6'd34;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Divider working registers
    logic [XLEN-1:0]    rem_p1;
    logic [XLEN-1:0]    quo_p1;
    logic [XLEN-1:0]    dvs_p1;
    logic [SHAMT_W-1:0] cnt_p1;
    logic               neg_q_p1;
    logic               neg_r_p1;
    logic               sel_rem_p1;

    logic signed [XLEN-1:0] op1_s, op2_s;
    logic                   accept;
    logic                   lt_s, lt_u, eq;
    logic [SHAMT_W-1:0]     shamt;

    logic                   is_div, div_signed, div_is_rem;
    logic                   div_zero, div_ovf, div_start;
    logic [XLEN-1:0]        op1_mag, op2_mag;

    logic                   mul_a_sx, mul_b_sx;
    logic [2*XLEN-1:0]      mul_a_w, mul_b_w, mul_prod;

    logic [XLEN:0]          div_shift;
    logic [XLEN-1:0]        div_diff, rem_nxt, quo_nxt;
    logic                   q_bit, div_last;
    logic [XLEN-1:0]        q_fin, r_fin, div_out;

    logic [XLEN-1:0]        base_res;
    logic                   base_br;

    assign op1_s  = op1;
    assign op2_s  = op2;
    assign lt_s   = op1_s < op2_s;
    assign lt_u   = op1 < op2;
    assign eq     = op1 == op2;
    assign shamt  = op2[SHAMT_W-1:0];

    assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
    assign busy     = (state_q == S_DIV);
    assign accept   = in_valid && in_ready;

    // ---- Stage p0: decode, operand conditioning, divide special cases ----
    assign is_div     = (alucode == ALU_DIV) || (alucode == ALU_DIVU) ||
                        (alucode == ALU_REM) || (alucode == ALU_REMU);
    assign div_signed = (alucode == ALU_DIV) || (alucode == ALU_REM);
    assign div_is_rem = (alucode == ALU_REM) || (alucode == ALU_REMU);
    assign div_zero   = (op2 == '0);
    assign div_ovf    = div_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (op2 == '1);
    // Only divides that need real iteration enter the DIV state.
    assign div_start  = accept && is_div && !div_zero && !div_ovf;

    assign op1_mag = (div_signed && op1[XLEN-1]) ? -op1 : op1;
    assign op2_mag = (div_signed && op2[XLEN-1]) ? -op2 : op2;

    // A 2*XLEN product of the extended operands is exact modulo 2^(2*XLEN),
    // which is all the high-half variants need.
    assign mul_a_sx = (alucode == ALU_MULH) || (alucode == ALU_MULHSU);
    assign mul_b_sx = (alucode == ALU_MULH);
    assign mul_a_w  = {{XLEN{mul_a_sx & op1[XLEN-1]}}, op1};
    assign mul_b_w  = {{XLEN{mul_b_sx & op2[XLEN-1]}}, op2};
    assign mul_prod = mul_a_w * mul_b_w;

    always_comb begin
        base_res = '0;
        base_br  = 1'b0;
        case (alucode)
            ALU_ADD:    base_res = op1 + op2;
            ALU_SUB:    base_res = op1 - op2;
            ALU_SLT:    base_res = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:   base_res = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:    base_res = op1 ^ op2;
            ALU_OR:     base_res = op1 | op2;
            ALU_AND:    base_res = op1 & op2;
            ALU_SLL:    base_res = op1 << shamt;
            ALU_SRL:    base_res = op1 >> shamt;
            ALU_SRA:    base_res = op1_s >>> shamt;
            ALU_LUI:    base_res = op2;
            ALU_JAL, ALU_JALR: begin
                base_res = op2 + XLEN'(4);
                base_br  = 1'b1;
            end
            ALU_BEQ:    base_br = eq;
            ALU_BNE:    base_br = !eq;
            ALU_BLT:    base_br = lt_s;
            ALU_BGE:    base_br = !lt_s;
            ALU_BLTU:   base_br = lt_u;
            ALU_BGEU:   base_br = !lt_u;
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW:
                        base_res = op1 + op2;
            ALU_MUL:    base_res = mul_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:
                        base_res = mul_prod[2*XLEN-1:XLEN];
            // Only the one-cycle special cases use these values; normal
            // divides take their result from the iterative path.
            ALU_DIV, ALU_DIVU:
                        base_res = div_zero ? '1 : op1;
            ALU_REM, ALU_REMU:
                        base_res = div_zero ? op1 : '0;
            default: begin
                base_res = '0;
                base_br  = 1'b0;
            end
        endcase
    end

    // ---- Stage p1: restoring divider iteration ----
    // Partial remainder is always below the divisor, so the shifted value
    // fits XLEN+1 bits and a successful subtraction fits XLEN bits.
    assign div_shift = {rem_p1, quo_p1[XLEN-1]};
    assign q_bit     = div_shift >= {1'b0, dvs_p1};
    assign div_diff  = div_shift[XLEN-1:0] - dvs_p1;
    assign rem_nxt   = q_bit ? div_diff : div_shift[XLEN-1:0];
    assign quo_nxt   = {quo_p1[XLEN-2:0], q_bit};
    assign div_last  = (state_q == S_DIV) && (cnt_p1 == SHAMT_W'(XLEN-1));

    assign q_fin   = neg_q_p1 ? -quo_nxt : quo_nxt;
    assign r_fin   = neg_r_p1 ? -rem_nxt : rem_nxt;
    assign div_out = sel_rem_p1 ? r_fin : q_fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (div_start) state_d = S_DIV;
            S_DIV:   if (div_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_p1     <= '0;
            quo_p1     <= '0;
            dvs_p1     <= '0;
            cnt_p1     <= '0;
            neg_q_p1   <= 1'b0;
            neg_r_p1   <= 1'b0;
            sel_rem_p1 <= 1'b0;
        end else if (div_start) begin
            rem_p1     <= '0;
            quo_p1     <= op1_mag;
            dvs_p1     <= op2_mag;
            cnt_p1     <= '0;
            neg_q_p1   <= div_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
            neg_r_p1   <= div_signed && op1[XLEN-1];
            sel_rem_p1 <= div_is_rem;
        end else if (state_q == S_DIV) begin
            rem_p1     <= rem_nxt;
            quo_p1     <= quo_nxt;
            cnt_p1     <= cnt_p1 + SHAMT_W'(1);
        end
    end

    // ---- Stage p2: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            br_taken  <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept && !div_start) begin
            result    <= base_res;
            br_taken  <= base_br;
            out_valid <= 1'b1;
        end else if (div_last) begin
            result    <= div_out;
            br_taken  <= 1'b0;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam logic [5:0] ADD = 6'd0,  SUB = 6'd1,  SLT = 6'd2,  SLTU = 6'd3;
    localparam logic [5:0] XOR_ = 6'd4, OR_ = 6'd5,  AND_ = 6'd6, SLL = 6'd7;
    localparam logic [5:0] SRL = 6'd8,  SRA = 6'd9,  LUI = 6'd10, JAL = 6'd11;
    localparam logic [5:0] JALR = 6'd12, BEQ = 6'd13, BNE = 6'd14, BLT = 6'd15;
    localparam logic [5:0] BGE = 6'd16, BLTU = 6'd17, BGEU = 6'd18, LW = 6'd21;
    localparam logic [5:0] MUL = 6'd27, MULH = 6'd28, MULHSU = 6'd29, MULHU = 6'd30;
    localparam logic [5:0] DIV = 6'd31, DIVU = 6'd32, REM = 6'd33, REMU = 6'd34;

    localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk, rst;
    logic        iv32, ir32, ov32, or32, br32, bz32;
    logic [5:0]  code32;
    logic [31:0] a32, b32, res32;
    logic        iv64, ir64, ov64, or64, br64, bz64;
    logic [5:0]  code64;
    logic [63:0] a64, b64, res64;

    int cur_w;
    int n_vec;
    int n_err;

    logic        o_valid, o_ready_in, o_br, o_busy;
    logic [63:0] o_res;

    alu_seq #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .alucode(code32),
        .op1(a32), .op2(b32), .out_valid(ov32), .out_ready(or32), .result(res32),
        .br_taken(br32), .busy(bz32)
    );

    alu_seq #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .alucode(code64),
        .op1(a64), .op2(b64), .out_valid(ov64), .out_ready(or64), .result(res64),
        .br_taken(br64), .busy(bz64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_valid    = ov64;
        o_ready_in = ir64;
        o_br       = br64;
        o_busy     = bz64;
        o_res      = res64;
        if (cur_w == 32) begin
            o_valid    = ov32;
            o_ready_in = ir32;
            o_br       = br32;
            o_busy     = bz32;
            o_res      = {32'h0, res32};
        end
    end

    function automatic logic [63:0] m(input int w, input logic [63:0] v);
        return (w == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic [5:0] code, input logic [63:0] a,
                         input logic [63:0] b, input logic v);
        if (w == 32) begin
            iv32 = v; code32 = code; a32 = a[31:0]; b32 = b[31:0];
        end else begin
            iv64 = v; code64 = code; a64 = a; b64 = b;
        end
    endtask

    task automatic set_ready(input logic r);
        or32 = r;
        or64 = r;
    endtask

    // One-cycle op: accepted on the next rising edge, result checked right after.
    task automatic op1c(input int w, input logic [5:0] code, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] er, input logic ebr,
                        input string tag);
        @(negedge clk);
        drive(w, code, a, b, 1'b1);
        chk({tag, ".in_ready"}, {63'h0, o_ready_in}, 64'h1);
        @(posedge clk);
        #1;
        drive(w, code, ~a, ~b, 1'b0);
        chk({tag, ".out_valid"}, {63'h0, o_valid}, 64'h1);
        chk({tag, ".result"}, o_res, m(w, er));
        chk({tag, ".br_taken"}, {63'h0, o_br}, {63'h0, ebr});
    endtask

    // Iterating divide: busy for w cycles, result in the cycle after that.
    task automatic opdiv(input int w, input logic [5:0] code, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] er, input string tag);
        @(negedge clk);
        drive(w, code, a, b, 1'b1);
        chk({tag, ".in_ready"}, {63'h0, o_ready_in}, 64'h1);
        @(posedge clk);
        #1;
        drive(w, code, ~a, ~b, 1'b0);
        for (int k = 0; k < w; k++) begin
            chk({tag, ".busy/in_ready/out_valid"},
                {61'h0, o_busy, o_ready_in, o_valid}, 64'b100);
            @(posedge clk);
            #1;
        end
        chk({tag, ".out_valid"}, {63'h0, o_valid}, 64'h1);
        chk({tag, ".busy_done"}, {63'h0, o_busy}, 64'h0);
        chk({tag, ".result"}, o_res, m(w, er));
        chk({tag, ".br_taken"}, {63'h0, o_br}, 64'h0);
    endtask

    task automatic suite(input int w);
        logic [63:0] msb;
        cur_w = w;
        msb = (w == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;

        op1c(w, ADD,  64'd5, 64'd6, 64'd11, 1'b0, "add");
        op1c(w, SUB,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub");
        op1c(w, SLT,  NEG1, 64'd1, 64'd1, 1'b0, "slt");
        op1c(w, SLTU, NEG1, 64'd1, 64'd0, 1'b0, "sltu");
        op1c(w, SRA,  msb, 64'd4,
             (w == 32) ? 64'hF800_0000 : 64'hF800_0000_0000_0000, 1'b0, "sra");
        op1c(w, SRL,  msb, 64'd4,
             (w == 32) ? 64'h0800_0000 : 64'h0800_0000_0000_0000, 1'b0, "srl");
        op1c(w, SLL,  64'd1, 64'h3F, msb, 1'b0, "sll_shamt");
        op1c(w, XOR_, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, "xor");
        op1c(w, OR_,  64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, "or");
        op1c(w, AND_, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, "and");
        op1c(w, LUI,  64'd9, 64'h1234_5000, 64'h1234_5000, 1'b0, "lui");
        op1c(w, LW,   64'h1000, NEG1, 64'hFFF, 1'b0, "lw_addr");
        op1c(w, BEQ,  64'd5, 64'd5, 64'd0, 1'b1, "beq");
        op1c(w, BNE,  64'd5, 64'd5, 64'd0, 1'b0, "bne");
        op1c(w, BLT,  NEG1, 64'd0, 64'd0, 1'b1, "blt");
        op1c(w, BGE,  NEG1, 64'd0, 64'd0, 1'b0, "bge");
        op1c(w, BLTU, NEG1, 64'd0, 64'd0, 1'b0, "bltu");
        op1c(w, BGEU, NEG1, 64'd0, 64'd0, 1'b1, "bgeu");
        op1c(w, JAL,  64'h2000, 64'h100, 64'h104, 1'b1, "jal");
        op1c(w, JALR, 64'h2000, 64'h200, 64'h204, 1'b1, "jalr");
        op1c(w, 6'd63, 64'd5, 64'd6, 64'd0, 1'b0, "unknown");

        op1c(w, MULH,   msb, msb,
             (w == 32) ? 64'h4000_0000 : 64'h4000_0000_0000_0000, 1'b0, "mulh");
        op1c(w, MULHSU, NEG1, 64'd2, NEG1, 1'b0, "mulhsu");
        op1c(w, MULHU,  NEG1, NEG1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "mulhu");
        op1c(w, MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mul");

        opdiv(w, DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div");
        opdiv(w, REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, NEG1, "rem");
        opdiv(w, DIVU, 64'd100, 64'd7, 64'd14, "divu");
        opdiv(w, REMU, 64'd100, 64'd7, 64'd2, "remu");
        opdiv(w, REMU, msb, NEG1, msb, "remu_big");

        op1c(w, DIV,  64'd123, 64'd0, NEG1, 1'b0, "div_by0");
        op1c(w, REMU, 64'd5, 64'd0, 64'd5, 1'b0, "remu_by0");
        op1c(w, DIV,  msb, NEG1, msb, 1'b0, "div_ovf");
        op1c(w, REM,  msb, NEG1, 64'd0, 1'b0, "rem_ovf");

        // Backpressure: result held, nothing accepted, then replace with no bubble.
        op1c(w, ADD, 64'd5, 64'd6, 64'd11, 1'b0, "bp_first");
        @(negedge clk);
        set_ready(1'b0);
        drive(w, ADD, 64'd1, 64'd1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp.result_hold", o_res, 64'd11);
            chk("bp.valid_hold", {63'h0, o_valid}, 64'h1);
            chk("bp.in_ready_low", {63'h0, o_ready_in}, 64'h0);
        end
        @(negedge clk);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        drive(w, ADD, 64'd0, 64'd0, 1'b0);
        chk("bp.replace_valid", {63'h0, o_valid}, 64'h1);
        chk("bp.replace_result", o_res, 64'd2);
        @(posedge clk);
        #1;
        chk("bp.valid_clears", {63'h0, o_valid}, 64'h0);

        // Reset in the middle of a divide.
        @(negedge clk);
        drive(w, DIVU, 64'd100, 64'd7, 1'b1);
        @(posedge clk);
        #1;
        drive(w, DIVU, 64'd0, 64'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("rstdiv.busy_before", {63'h0, o_busy}, 64'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstdiv.in_ready", {63'h0, o_ready_in}, 64'h1);
        chk("rstdiv.busy", {63'h0, o_busy}, 64'h0);
        for (int k = 0; k < w + 4; k++) begin
            chk("rstdiv.no_valid", {63'h0, o_valid}, 64'h0);
            @(posedge clk);
            #1;
        end
        op1c(w, ADD, 64'd2, 64'd3, 64'd5, 1'b0, "after_rst");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cur_w = 32;
        rst   = 1'b1;
        iv32 = 1'b0; code32 = '0; a32 = '0; b32 = '0;
        iv64 = 1'b0; code64 = '0; a64 = '0; b64 = '0;
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst32.out_valid", {63'h0, ov32}, 64'h0);
        chk("rst32.result",    {32'h0, res32}, 64'h0);
        chk("rst32.br_taken",  {63'h0, br32}, 64'h0);
        chk("rst32.busy",      {63'h0, bz32}, 64'h0);
        chk("rst32.in_ready",  {63'h0, ir32}, 64'h1);
        chk("rst64.out_valid", {63'h0, ov64}, 64'h0);
        chk("rst64.result",    res64, 64'h0);
        chk("rst64.busy",      {63'h0, bz64}, 64'h0);
        chk("rst64.in_ready",  {63'h0, ir64}, 64'h1);

        suite(32);
        suite(64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational execute-stage ALU. It sits between decode/register-read and write-back, and implements the full RV32I/RV64I ALU and branch operation set plus the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Base operations and multiplies complete in one cycle. Divides and remainders use a radix-2 restoring iterative divider. Every result is registered and delivered over a valid/ready handshake, so the pipeline stalls cleanly on long operations.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- SHAMT_W, $clog2(XLEN), number of shift-amount bits taken from op2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  the operation on alucode/op1/op2 is valid.
- in_ready  out  1  the block accepts an operation this cycle.
- alucode  in  6  operation select; uses the define.vh ALU_* codes, with new codes ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU added there.
- op1  in  XLEN  operand 1 (rs1 or PC).
- op2  in  XLEN  operand 2 (rs2 or immediate).
- out_valid  out  1  result and br_taken are valid.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  XLEN  registered result.
- br_taken  out  1  registered branch/jump-taken flag.
- busy  out  1  the divider is iterating.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- State machine:
  - IDLE: on accept of a non-divide op, or a divide special case, write the output register and stay in IDLE. On accept of a normal divide, latch the operands and go to DIV.
  - DIV: iterate one quotient bit per cycle for XLEN cycles. On the last iteration, write the output register and go to IDLE.
- Base ops:
  - ADD/SUB/XOR/OR/AND: conventional.
  - SLT: signed compare. SLTU: unsigned compare. Result is 0 or 1.
  - SLL/SRL/SRA: shift amount is op2[SHAMT_W-1:0]. SRL is logical; SRA is arithmetic.
  - LUI: result = op2.
  - JAL/JALR: result = op2+4, br_taken=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result = 0, br_taken = comparison outcome (signed for BLT/BGE, unsigned for the U variants).
  - Loads/stores (LB..LHU, SB..SW): result = op1+op2, br_taken=0.
  - Unknown code: result = 0, br_taken = 0.
  - br_taken = 0 for every op not listed above as a jump or branch.
- Multiply:
  - Full 2*XLEN product, operands sign-extended per variant: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; the MULH* variants return the high XLEN bits.
- Divide:
  - Signed variants divide magnitudes and then apply sign correction. The quotient is negative when the operand signs differ; the remainder takes the dividend's sign.
  - Divisor 0: quotient = all-ones, remainder = op1. Completes in one cycle.
  - Signed overflow (op1 = most-negative, op2 = -1): quotient = op1, remainder = 0. Completes in one cycle.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - out_valid clears when the result is taken and no new result is written in the same cycle.

## Timing
- Reset values:
  - Outputs: out_valid=0, result=0, br_taken=0, busy=0, in_ready=1 in the cycle after reset deasserts.
  - State: IDLE; divider registers cleared.
- Latency, with the op accepted in cycle T:
  - Base ops, multiplies and divide special cases: out_valid=1 from cycle T+1.
  - Normal divides: out_valid=1 from cycle T+XLEN+1. busy=1 for cycles T+1..T+XLEN.
- Throughput:
  - One op per cycle while out_ready=1 (back-to-back accepts allowed).
  - A divide blocks new accepts until its result is written.
- Simultaneous events: out_ready=1 together with a new accept in the same cycle replaces the result register with no bubble.
- Backpressure: while out_valid && !out_ready, in_ready=0 and nothing is accepted.
- Reset mid-operation: rst asserted during DIV aborts the divide and returns to IDLE. No out_valid is produced for the aborted op.
- Input stability: operands are sampled only at accept; later input changes do not affect an in-flight divide.

## Test plan
- Base ops at XLEN=32, out_ready=1, one op per cycle:
  - SLT 0xFFFFFFFF, 1 -> 1; SLTU -> 0; SRA 0x80000000, 4 -> 0xF8000000; SRL -> 0x08000000.
  - Each result appears exactly one cycle after accept.
- Branch and jump:
  - BLT -1, 0 -> br_taken=1; BLTU -1, 0 -> 0.
  - JAL op2=0x100 -> result 0x104, br_taken=1.
- Multiply:
  - MULH 0x80000000, 0x80000000 -> 0x40000000.
  - MULHSU -1, 2 -> 0xFFFFFFFF.
  - MULHU -1, -1 -> 0xFFFFFFFE.
  - MUL 7, -3 -> 0xFFFFFFEB.
- Divide:
  - DIV -7, 2 -> -3; REM -7, 2 -> -1.
  - DIVU 100, 7 -> 14.
  - out_valid exactly 33 cycles after accept; busy high for 32 cycles; in_ready low throughout.
- Divide special cases:
  - DIV x, 0 -> 0xFFFFFFFF; REMU 5, 0 -> 5.
  - DIV 0x80000000, -1 -> 0x80000000; REM of the same operands -> 0.
  - All complete in one cycle.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: result stable, in_ready=0.
  - Assert rst mid-DIV: out_valid stays 0 and in_ready=1 after reset.
  - Repeat the full suite at XLEN=64.
